serial_frame_feeder: RTL and testbench

Upstream stage for the divisible-by-3 Mealy FSM. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. The serial bit drives the FSM's data_in, together with bit-valid and frame-boundary strobes. An optional idle gap between frames gives the downstream FSM a clean restart point.

---
 rtl/ser_pkg.sv | 24 ++
 rtl/serial_frame_feeder_down_counter.sv | 39 +++
 rtl/serial_frame_feeder.sv | 157 +++++++++++++++
 tb/tb_serial_frame_feeder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the serial frame feeder: FSM state encoding and the
// legal ranges of the WIDTH and GAP parameters.
// ---------------------------------------------------------------------------
package ser_pkg;

   // 2-bit binary state encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Legal parameter ranges.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;
   localparam int GAP_MIN   = 0;
   localparam int GAP_MAX   = 15;

   // The gap counter is sized to hold the largest legal GAP-1.
   localparam int GAP_CNT_W = $clog2(GAP_MAX + 1);

endpackage

// File: rtl/serial_frame_feeder_down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
// Loadable down counter that saturates at zero.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (count -> 0)
//   load   : load LOAD_VALUE (has priority over dec)
//   dec    : decrement by one; ignored when already zero
//   count  : current value
//   zero   : high while count == 0
// ---------------------------------------------------------------------------
module down_counter #(
   parameter int CNT_W      = 4,
   parameter int LOAD_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   localparam logic [CNT_W-1:0] LOAD_BITS = CNT_W'(LOAD_VALUE);

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_BITS;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/serial_frame_feeder.sv
// ---------------------------------------------------------------------------
// serial_frame_feeder
// Accepts a parallel word over a valid/ready handshake and shifts it out
// MSB-first, one bit per clock, with bit-valid and frame-boundary strobes.
// An optional idle gap of GAP cycles follows every frame.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   load_valid  : producer offers load_data
//   load_data   : word to serialize, bit WIDTH-1 first
//   load_ready  : word can be accepted this cycle (decoded from state only)
//   data_out    : serial bit
//   bit_valid   : data_out carries a frame bit
//   frame_start : first (MSB) bit of a frame
//   frame_last  : last (LSB) bit of a frame
// ---------------------------------------------------------------------------
module serial_frame_feeder
   import ser_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             data_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_last
);

   localparam int BIT_CNT_W = $clog2(WIDTH);
   localparam int GAP_LOAD  = (GAP > 0) ? GAP - 1 : 0;
   localparam bit HAS_GAP   = (GAP != 0);

   state_e               state, state_nxt;
   logic [WIDTH-1:0]     shift_reg;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic                 bit_zero;
   logic [GAP_CNT_W-1:0] gap_cnt_unused;
   logic                 gap_zero;
   logic                 accept;
   logic                 bit_dec;
   logic                 gap_load;
   logic                 gap_dec;

   // Bits still to send after the one currently on data_out.
   down_counter #(
      .CNT_W      (BIT_CNT_W),
      .LOAD_VALUE (WIDTH - 1)
   ) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .dec   (bit_dec),
      .count (bit_cnt),
      .zero  (bit_zero)
   );

   // Idle cycles remaining after a frame; only the zero flag matters here.
   down_counter #(
      .CNT_W      (GAP_CNT_W),
      .LOAD_VALUE (GAP_LOAD)
   ) u_gap_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (gap_load),
      .dec   (gap_dec),
      .count (gap_cnt_unused),
      .zero  (gap_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      accept     = 1'b0;
      bit_dec    = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!bit_zero) begin
               bit_dec = 1'b1;
            end else if (HAS_GAP) begin
               gap_load  = 1'b1;
               state_nxt = ST_GAP;
            end else begin
               // Last bit on the wire: the next word may follow with no bubble.
               load_ready = 1'b1;
               if (load_valid) begin
                  accept = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_nxt = ST_IDLE;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // data_out is the shift register MSB itself. A frame is shifted WIDTH times
   // while in SHIFT, so the register is all-zero whenever no frame is in flight.
   // NOTE: the shift register is a plain flop bank, so it is reset like any
   // other state; that reset is what guarantees data_out=0 out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
      end else if (accept) begin
         shift_reg <= load_data;
      end else if (state == ST_SHIFT) begin
         shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   assign data_out = shift_reg[WIDTH-1];

   // Strobes are registered from next-cycle values. frame_last is armed while
   // one bit remains; a load can never coincide with that, since load_ready
   // in SHIFT requires the counter to be zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_last  <= 1'b0;
      end else begin
         bit_valid   <= (state_nxt == ST_SHIFT);
         frame_start <= accept;
         frame_last  <= (state == ST_SHIFT) && (bit_cnt == BIT_CNT_W'(1));
      end
   end

endmodule

// File: tb/tb_serial_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_feeder
// Three feeder instances: a (WIDTH=5, GAP=0), b (WIDTH=5, GAP=2) and
// c (WIDTH=2, GAP=0). Every accepted word pushes its expected MSB-first bit
// stream into a per-instance queue; a monitor per instance pops and compares
// each valid bit, and checks that outputs are quiet between frames.
// ---------------------------------------------------------------------------
module tb_serial_frame_feeder;

   typedef struct packed {
      logic d;
      logic first;
      logic last;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;

   logic       lv_a = 1'b0;
   logic [4:0] ld_a = '0;
   logic       ready_a, do_a, bv_a, fs_a, fl_a;

   logic       lv_b = 1'b0;
   logic [4:0] ld_b = '0;
   logic       ready_b, do_b, bv_b, fs_b, fl_b;

   logic       lv_c = 1'b0;
   logic [1:0] ld_c = '0;
   logic       ready_c, do_c, bv_c, fs_c, fl_c;

   int   checks = 0;
   int   errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   int   run_a      = 0;
   int   last_run_a = 0;

   always #5 clk = ~clk;

   serial_frame_feeder #(.WIDTH(5), .GAP(0)) dut_a (
      .clk(clk), .reset(reset), .load_valid(lv_a), .load_data(ld_a),
      .load_ready(ready_a), .data_out(do_a), .bit_valid(bv_a),
      .frame_start(fs_a), .frame_last(fl_a)
   );

   serial_frame_feeder #(.WIDTH(5), .GAP(2)) dut_b (
      .clk(clk), .reset(reset), .load_valid(lv_b), .load_data(ld_b),
      .load_ready(ready_b), .data_out(do_b), .bit_valid(bv_b),
      .frame_start(fs_b), .frame_last(fl_b)
   );

   serial_frame_feeder #(.WIDTH(2), .GAP(0)) dut_c (
      .clk(clk), .reset(reset), .load_valid(lv_c), .load_data(ld_c),
      .load_ready(ready_c), .data_out(do_c), .bit_valid(bv_c),
      .frame_start(fs_c), .frame_last(fl_c)
   );

   // ---------------- monitors (sample on the falling edge) ----------------
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!reset) begin
         run_a = 0;
      end else if (bv_a) begin
         run_a++;
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_bit: data/start/last=%b with no frame pending", {do_a, fs_a, fl_a});
         end else begin
            e = q_a.pop_front();
            if ({do_a, fs_a, fl_a} !== e)
               begin errors++; $display("FAIL a_bit: data/start/last=%b required %b", {do_a, fs_a, fl_a}, e); end
         end
         if (fl_a) begin
            checks++;
            if (ready_a !== 1'b1)
               begin errors++; $display("FAIL a_ready_at_last: load_ready=%b required 1", ready_a); end
         end
      end else begin
         if (run_a != 0) last_run_a = run_a;
         run_a = 0;
         checks++;
         if ({do_a, fs_a, fl_a} !== 3'b000)
            begin errors++; $display("FAIL a_idle_outputs: data/start/last=%b required 000", {do_a, fs_a, fl_a}); end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (reset && bv_b) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_bit: data/start/last=%b with no frame pending", {do_b, fs_b, fl_b});
         end else begin
            e = q_b.pop_front();
            if ({do_b, fs_b, fl_b} !== e)
               begin errors++; $display("FAIL b_bit: data/start/last=%b required %b", {do_b, fs_b, fl_b}, e); end
         end
         if (fl_b) begin
            checks++;
            if (ready_b !== 1'b0)
               begin errors++; $display("FAIL b_ready_at_last: load_ready=%b required 0", ready_b); end
         end
      end else if (reset) begin
         checks++;
         if ({do_b, fs_b, fl_b} !== 3'b000)
            begin errors++; $display("FAIL b_idle_outputs: data/start/last=%b required 000", {do_b, fs_b, fl_b}); end
      end
   end

   always @(negedge clk) begin : mon_c
      exp_t e;
      if (reset && bv_c) begin
         checks++;
         if (q_c.size() == 0) begin
            errors++;
            $display("FAIL c_unexpected_bit: data/start/last=%b with no frame pending", {do_c, fs_c, fl_c});
         end else begin
            e = q_c.pop_front();
            if ({do_c, fs_c, fl_c} !== e)
               begin errors++; $display("FAIL c_bit: data/start/last=%b required %b", {do_c, fs_c, fl_c}, e); end
         end
         if (fl_c) begin
            checks++;
            if (ready_c !== 1'b1)
               begin errors++; $display("FAIL c_ready_at_last: load_ready=%b required 1", ready_c); end
         end
      end else if (reset) begin
         checks++;
         if ({do_c, fs_c, fl_c} !== 3'b000)
            begin errors++; $display("FAIL c_idle_outputs: data/start/last=%b required 000", {do_c, fs_c, fl_c}); end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic ready_of(input int id);
      case (id)
         0:       return ready_a;
         1:       return ready_b;
         default: return ready_c;
      endcase
   endfunction

   function automatic logic busy_of(input int id);
      case (id)
         0:       return (q_a.size() != 0) || bv_a;
         1:       return (q_b.size() != 0) || bv_b;
         default: return (q_c.size() != 0) || bv_c;
      endcase
   endfunction

   task automatic drive(input int id, input logic v, input logic [31:0] word);
      case (id)
         0:       begin lv_a = v; ld_a = word[4:0]; end
         1:       begin lv_b = v; ld_b = word[4:0]; end
         default: begin lv_c = v; ld_c = word[1:0]; end
      endcase
   endtask

   // Expected stream of one frame: MSB first, start on the first, last on the LSB.
   task automatic push_exp(input int id, input logic [31:0] word);
      exp_t e;
      int   w;
      w = (id == 2) ? 2 : 5;
      for (int i = w - 1; i >= 0; i--) begin
         e.d     = word[i];
         e.first = (i == w - 1);
         e.last  = (i == 0);
         case (id)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
         endcase
      end
   endtask

   // Called at a falling edge. Holds valid until ready is seen, records the
   // expected frame, and returns at the falling edge after the accepting edge
   // with load_valid still asserted.
   task automatic offer(input int id, input logic [31:0] word);
      int n;
      n = 0;
      drive(id, 1'b1, word);
      while (ready_of(id) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL offer_timeout: inst %0d load_ready=%b after %0d cycles, required 1", id, ready_of(id), n);
      end else begin
         push_exp(id, word);
      end
      @(negedge clk);
   endtask

   task automatic drain(input int id);
      int n;
      n = 0;
      while (busy_of(id) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL drain_timeout: inst %0d still busy after %0d cycles, required idle", id, n);
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready_a, do_a, bv_a, fs_a, fl_a} !== 5'b10000)
         begin errors++; $display("FAIL reset_a: ready/data/valid/start/last=%b required 10000", {ready_a, do_a, bv_a, fs_a, fl_a}); end
      checks++;
      if ({ready_b, do_b, bv_b, fs_b, fl_b} !== 5'b10000)
         begin errors++; $display("FAIL reset_b: ready/data/valid/start/last=%b required 10000", {ready_b, do_b, bv_b, fs_b, fl_b}); end
      checks++;
      if ({ready_c, do_c, bv_c, fs_c, fl_c} !== 5'b10000)
         begin errors++; $display("FAIL reset_c: ready/data/valid/start/last=%b required 10000", {ready_c, do_c, bv_c, fs_c, fl_c}); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_frame();
      offer(0, 32'b10101);
      drive(0, 1'b0, 32'd0);
      drain(0);
      checks++;
      if (last_run_a !== 5)
         begin errors++; $display("FAIL single_run_len: bit_valid run=%0d required 5", last_run_a); end
   endtask

   task automatic test_back_to_back();
      offer(0, 32'b11000);
      offer(0, 32'b00011);
      drive(0, 1'b0, 32'd0);
      drain(0);
      checks++;
      if (last_run_a !== 10)
         begin errors++; $display("FAIL b2b_run_len: bit_valid run=%0d required 10", last_run_a); end
   endtask

   task automatic test_gap();
      offer(1, 32'b11111);             // frame 1 bit 1 visible, valid held
      repeat (4) @(negedge clk);       // bits 2..5
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bv_b, ready_b} !== {1'b0, (i == 2)})
            begin errors++; $display("FAIL gap_cycle%0d: valid/ready=%b required %b", i, {bv_b, ready_b}, {1'b0, (i == 2)}); end
         if (i == 2) push_exp(1, 32'b11111);
      end
      @(negedge clk);
      drive(1, 1'b0, 32'd0);
      drain(1);
   endtask

   task automatic test_busy_ignore();
      offer(0, 32'b10000);
      drive(0, 1'b1, 32'b01111);
      checks++;
      if (ready_a !== 1'b0)
         begin errors++; $display("FAIL busy_ready: load_ready=%b required 0", ready_a); end
      @(negedge clk);
      drive(0, 1'b0, 32'd0);
      drain(0);
      checks++;
      if (last_run_a !== 5)
         begin errors++; $display("FAIL busy_run_len: bit_valid run=%0d required 5", last_run_a); end
   endtask

   task automatic test_reset_mid_frame();
      offer(0, 32'b10110);             // bit 1 visible
      drive(0, 1'b0, 32'd0);
      repeat (2) @(negedge clk);       // bit 3 visible
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({ready_a, do_a, bv_a, fs_a, fl_a} !== 5'b10000)
         begin errors++; $display("FAIL midreset_outputs: ready/data/valid/start/last=%b required 10000", {ready_a, do_a, bv_a, fs_a, fl_a}); end
      q_a.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      offer(0, 32'b00001);
      drive(0, 1'b0, 32'd0);
      drain(0);
      checks++;
      if (last_run_a !== 5)
         begin errors++; $display("FAIL midreset_run_len: bit_valid run=%0d required 5", last_run_a); end
   endtask

   task automatic test_width2();
      offer(2, 32'b01);
      drive(2, 1'b0, 32'd0);
      drain(2);
      offer(2, 32'b10);
      offer(2, 32'b11);
      drive(2, 1'b0, 32'd0);
      drain(2);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gap();
      test_busy_ignore();
      test_reset_mid_frame();
      test_width2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
